rpg_prbs_gen: RTL and testbench
===============================

# rpg_prbs_gen

Reference pattern generator (RPG) feeding the 22nm test chain. It produces a PRBS or fixed bit stream on `PAT_OUT`, which drives the DUT chain input. It also produces a programmably delayed copy on `RPG_OUT`, which feeds the error checker's `RPG_IN`, so that both sides of the checker's comparator see the same bit. A run is started and stopped through a small FSM and has a programmable length.

## Interface
- `MAX_DLY`, 15: maximum alignment delay in cycles (delay line depth).
- `CLK` input 1: sole clock; all logic on its rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `START` input 1: single-cycle pulse; begins a run.
- `STOP` input 1: single-cycle pulse; aborts a run.
- `MODE` input 2: pattern select. 00 PRBS7, 01 PRBS15, 10 PRBS31, 11 checkerboard 1010…
- `SEED` input 31: LFSR seed, sampled at START.
- `RUN_LEN` input 32: number of bits per run; 0 = free-run until STOP.
- `DLY` input 4: `RPG_OUT` alignment delay, 0..MAX_DLY; quasi-static.
- `INJ_ERR` input 1: error-inject pulse (only present with the macro).
- `PAT_OUT` output 1: pattern bit to the DUT chain.
- `RPG_OUT` output 1: delayed pattern bit to the checker.
- `RUNNING` output 1: high while in RUN.
- `DONE` output 1: high in DONE state.
- `BIT_CNT` output 32: bits emitted in the current or last run.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE → LOAD on START.
  - LOAD → RUN after one cycle.
  - RUN → DONE when `BIT_CNT` reaches `RUN_LEN` (`RUN_LEN` ≠ 0), or on STOP.
  - DONE → LOAD on START.
  - START is ignored while in RUN.
  - STOP in IDLE, LOAD or DONE is ignored.
  - If STOP and START arrive in the same cycle, STOP wins.
- LOAD state:
  - `SEED` is masked to the mode width (7/15/31 bits).
  - A masked seed of zero is replaced by all-ones to prevent LFSR lockup.
  - `BIT_CNT` is cleared.
  - Checkerboard mode starts with 1.
- LFSR is Fibonacci, state `s[30:0]`, shifting `s <= {s[29:0], b}`; the output bit is `b`.
  - PRBS7: `b = s[6]^s[5]`.
  - PRBS15: `b = s[14]^s[13]`.
  - PRBS31: `b = s[30]^s[27]`.
- In RUN, one bit is emitted per cycle and `BIT_CNT` increments by one.
  - `BIT_CNT` wraps modulo 2^32 in free-run.
  - `BIT_CNT` holds its value in DONE and IDLE.
- Outside RUN, `PAT_OUT` is 0 and the LFSR holds its state.
- `MODE` changes during RUN take effect only at the next LOAD.
- `RPG_OUT` is `PAT_OUT` delayed by `DLY` cycles through a shift register of depth `MAX_DLY`.
  - `DLY` values greater than `MAX_DLY` saturate to `MAX_DLY`.
  - Zeros are shifted in while not running.
- Reset values: state IDLE; `PAT_OUT`, `RPG_OUT`, `RUNNING`, `DONE` all 0; `BIT_CNT` 0; LFSR all-ones; delay line all 0.
- Reset asserted mid-run returns the block to IDLE immediately. No DONE is produced.

## Timing
- START is sampled at edge n. LOAD occupies cycle n+1. The first pattern bit appears registered on `PAT_OUT` after edge n+2, with `RUNNING` = 1 from the same edge.
- `RUN_LEN` = N produces exactly N bits. `DONE` rises on the edge after the Nth bit, and `PAT_OUT` returns to 0 on that same edge.
- STOP sampled at edge m: the bit emitted at m is the last one, and `DONE` follows on edge m+1.
- `RPG_OUT` lags `PAT_OUT` by exactly `DLY` cycles. `DLY` = 0 gives an identical waveform.

## Configuration
- `RPG_ERR_INJECT_EN` defined:
  - The `INJ_ERR` port exists.
  - An `INJ_ERR` pulse in RUN inverts the next `PAT_OUT` bit only. `RPG_OUT` is not affected, and neither are the LFSR state nor `BIT_CNT`.
  - Each pulse yields exactly one checker mismatch.
  - Pulses outside RUN are dropped.
- Macro undefined: no `INJ_ERR` port and no injection logic. `PAT_OUT` is always the pure pattern.

## Structure
- Package `rpg_pkg`:
  - `MODE` encodings.
  - FSM state enum.
  - Per-mode width and tap constants.
  - Seed mask constants.
- Sub-module `rpg_lfsr`: mode-selectable LFSR with load and enable. It holds the pattern datapath only; the FSM, counter, delay line and injection logic stay in the top level.

## Test plan
- PRBS7, `SEED` 7'h7F, `RUN_LEN` 10, `DLY` 0 → `PAT_OUT` 0,0,0,0,0,0,1,… starting 2 cycles after START; `DONE` after 10 bits; `BIT_CNT` = 10.
- PRBS7, free-run for 254 bits → the sequence repeats with period 127; no all-zero lockup.
- `SEED` 0 in PRBS15 → behaves exactly as seed 15'h7FFF.
- Checkerboard, `DLY` 5 → `RPG_OUT` equals `PAT_OUT` shifted by 5 cycles; `DLY` 15 gives a 15-cycle shift.
- Free-run then STOP at bit 100; START reasserted with STOP in the same cycle; `RST_N` low mid-run → `BIT_CNT` = 100 and DONE; STOP wins; immediate return to IDLE with all outputs 0.
- With `RPG_ERR_INJECT_EN`, three `INJ_ERR` pulses in RUN and one in IDLE → `PAT_OUT` and `RPG_OUT` differ in exactly 3 bits; downstream error count = 3.

Source files
------------

// File: rtl/rpg_pkg.sv
// Shared encodings, FSM states and per-mode LFSR constants for the reference pattern generator.
package rpg_pkg;

    typedef enum logic [1:0] {
        MODE_PRBS7   = 2'b00,
        MODE_PRBS15  = 2'b01,
        MODE_PRBS31  = 2'b10,
        MODE_CHECKER = 2'b11
    } rpg_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } rpg_state_e;

    localparam int PRBS7_W  = 7;
    localparam int PRBS15_W = 15;
    localparam int PRBS31_W = 31;

    localparam int PRBS7_TAP_A  = PRBS7_W - 1;
    localparam int PRBS7_TAP_B  = 5;
    localparam int PRBS15_TAP_A = PRBS15_W - 1;
    localparam int PRBS15_TAP_B = 13;
    localparam int PRBS31_TAP_A = PRBS31_W - 1;
    localparam int PRBS31_TAP_B = 27;

    localparam logic [30:0] PRBS7_MASK  = 31'((64'd1 << PRBS7_W) - 64'd1);
    localparam logic [30:0] PRBS15_MASK = 31'((64'd1 << PRBS15_W) - 64'd1);
    localparam logic [30:0] PRBS31_MASK = 31'((64'd1 << PRBS31_W) - 64'd1);

    // A masked seed of zero would lock the LFSR, so it becomes all-ones of the mode width;
    // checkerboard has an empty mask and therefore always starts from a cleared state.
    function automatic logic [30:0] seed_init(input rpg_mode_e mode, input logic [30:0] seed);
        logic [30:0] mask;
        logic [30:0] masked;
        case (mode)
            MODE_PRBS7:  mask = PRBS7_MASK;
            MODE_PRBS15: mask = PRBS15_MASK;
            MODE_PRBS31: mask = PRBS31_MASK;
            default:     mask = '0;
        endcase
        masked = seed & mask;
        return (masked == '0) ? mask : masked;
    endfunction

endpackage

// File: rtl/rpg_lfsr.sv
// Mode-selectable Fibonacci LFSR / checkerboard source; mode is latched at load.
module rpg_lfsr
    import rpg_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        load,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [30:0] seed,
    output logic        pat_bit
);

    rpg_mode_e   mode_r;
    logic [30:0] lfsr_s;

    // Checkerboard toggles s[0]; a cleared state therefore emits 1 first.
    always_comb begin
        pat_bit = 1'b0;
        case (mode_r)
            MODE_PRBS7:  pat_bit = lfsr_s[PRBS7_TAP_A] ^ lfsr_s[PRBS7_TAP_B];
            MODE_PRBS15: pat_bit = lfsr_s[PRBS15_TAP_A] ^ lfsr_s[PRBS15_TAP_B];
            MODE_PRBS31: pat_bit = lfsr_s[PRBS31_TAP_A] ^ lfsr_s[PRBS31_TAP_B];
            default:     pat_bit = ~lfsr_s[0];
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lfsr_s <= '1;
            mode_r <= MODE_PRBS7;
        end else if (load) begin
            lfsr_s <= seed_init(rpg_mode_e'(mode), seed);
            mode_r <= rpg_mode_e'(mode);
        end else if (en) begin
            lfsr_s <= {lfsr_s[29:0], pat_bit};
        end
    end

endmodule

// File: rtl/rpg_prbs_gen.sv
// Reference pattern generator: run FSM, bit counter and RPG_OUT alignment delay line.
// Optional RPG_ERR_INJECT_EN adds INJ_ERR, which flips single PAT_OUT bits during a run.
module rpg_prbs_gen
    import rpg_pkg::*;
#(
    parameter int MAX_DLY = 15
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        STOP,
    input  logic [1:0]  MODE,
    input  logic [30:0] SEED,
    input  logic [31:0] RUN_LEN,
    input  logic [3:0]  DLY,
`ifdef RPG_ERR_INJECT_EN
    input  logic        INJ_ERR,
`endif
    output logic        PAT_OUT,
    output logic        RPG_OUT,
    output logic        RUNNING,
    output logic        DONE,
    output logic [31:0] BIT_CNT
);

    localparam logic [3:0] MAX_DLY_L = 4'(MAX_DLY);

    function automatic logic [3:0] sat_dly(input logic [3:0] d);
        return (d > MAX_DLY_L) ? MAX_DLY_L : d;
    endfunction

    rpg_state_e         state;
    rpg_state_e         state_nxt;
    logic               run_en;
    logic               lfsr_bit;
    logic               at_end;
    logic [31:0]        cnt_inc;
    logic               pat_p0;
    logic               vld_p0;
    logic [MAX_DLY-1:0] dly_p1;
    logic [3:0]         dly_sel;

    assign run_en  = (state == ST_RUN);
    assign cnt_inc = BIT_CNT + 32'd1;
    assign at_end  = (RUN_LEN != 32'd0) && (cnt_inc == RUN_LEN);

    rpg_lfsr u_lfsr (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .load    (state == ST_LOAD),
        .en      (run_en),
        .mode    (MODE),
        .seed    (SEED),
        .pat_bit (lfsr_bit)
    );

    // STOP suppresses a simultaneous START; the last RUN cycle still emits its bit.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (START && !STOP) state_nxt = ST_LOAD;
            ST_LOAD:          state_nxt = ST_RUN;
            ST_RUN:           if (STOP || at_end) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // p0: registered pattern bit with its valid
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            BIT_CNT <= '0;
            pat_p0  <= 1'b0;
            vld_p0  <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state  <= state_nxt;
            pat_p0 <= run_en & lfsr_bit;
            vld_p0 <= run_en;
            DONE   <= (state == ST_DONE);
            if (state == ST_LOAD) begin
                BIT_CNT <= '0;
            end else if (run_en) begin
                BIT_CNT <= cnt_inc;
            end
        end
    end

    assign RUNNING = vld_p0;

    // p1: alignment delay line, fed from the uncorrupted pattern
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dly_p1 <= '0;
        end else begin
            dly_p1 <= {dly_p1[MAX_DLY-2:0], pat_p0 & vld_p0};
        end
    end

    assign dly_sel = sat_dly(DLY);
    assign RPG_OUT = (dly_sel == 4'd0) ? pat_p0 : dly_p1[dly_sel - 4'd1];

`ifdef RPG_ERR_INJECT_EN
    logic flip_p0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flip_p0 <= 1'b0;
        end else begin
            flip_p0 <= run_en & INJ_ERR;
        end
    end

    assign PAT_OUT = pat_p0 ^ flip_p0;
`else
    assign PAT_OUT = pat_p0;
`endif

endmodule

// File: tb/tb_rpg_prbs_gen.sv
// Directed bench for rpg_prbs_gen: PRBS7/15/31 heads, period, seed masking, delay line, STOP, reset.
module tb_rpg_prbs_gen;

    logic        CLK     = 1'b0;
    logic        RST_N   = 1'b0;
    logic        START   = 1'b0;
    logic        STOP    = 1'b0;
    logic [1:0]  MODE    = 2'b00;
    logic [30:0] SEED    = '0;
    logic [31:0] RUN_LEN = '0;
    logic [3:0]  DLY     = '0;
`ifdef RPG_ERR_INJECT_EN
    logic        INJ_ERR = 1'b0;
`endif
    logic        PAT_OUT;
    logic        RPG_OUT;
    logic        RUNNING;
    logic        DONE;
    logic [31:0] BIT_CNT;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] pv;
    logic [63:0] rv;
    logic [63:0] av;
    logic        ring [254];

    always #5 CLK = ~CLK;

    rpg_prbs_gen #(.MAX_DLY(15)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .START   (START),
        .STOP    (STOP),
        .MODE    (MODE),
        .SEED    (SEED),
        .RUN_LEN (RUN_LEN),
        .DLY     (DLY),
`ifdef RPG_ERR_INJECT_EN
        .INJ_ERR (INJ_ERR),
`endif
        .PAT_OUT (PAT_OUT),
        .RPG_OUT (RPG_OUT),
        .RUNNING (RUNNING),
        .DONE    (DONE),
        .BIT_CNT (BIT_CNT)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns on the falling edge after START was sampled (FSM now in LOAD).
    task automatic start_run(input logic [1:0] m, input logic [30:0] s,
                             input logic [31:0] len, input logic [3:0] d);
        @(negedge CLK);
        MODE = m; SEED = s; RUN_LEN = len; DLY = d; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (DONE !== 1'b1 && k < 300) begin
            @(negedge CLK);
            k++;
        end
        chk(tag, 64'(DONE), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_ok;
        int mism;
        int ones;
        int diff;

        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_pat", 64'(PAT_OUT), 64'd0);
        chk("rst_rpg", 64'(RPG_OUT), 64'd0);
        chk("rst_running", 64'(RUNNING), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_cnt", 64'(BIT_CNT), 64'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // PRBS7 seed 7F, 10 bits, DLY 0
        start_run(2'b00, 31'h7F, 32'd10, 4'd0);
        @(negedge CLK);
        chk("p7_load_running", 64'(RUNNING), 64'd0);
        chk("p7_load_pat", 64'(PAT_OUT), 64'd0);
        pv = '0; rv = '0; run_ok = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            pv[i] = PAT_OUT;
            rv[i] = RPG_OUT;
            if (RUNNING !== 1'b1) run_ok = 0;
        end
        chk("p7_bits", pv, 64'h040);
        chk("p7_rpg_dly0", rv, 64'h040);
        chk("p7_running", 64'(run_ok), 64'd1);
        @(negedge CLK);
        chk("p7_done", 64'(DONE), 64'd1);
        chk("p7_pat_zero", 64'(PAT_OUT), 64'd0);
        chk("p7_running_off", 64'(RUNNING), 64'd0);
        chk("p7_cnt", 64'(BIT_CNT), 64'd10);

        // PRBS7 free-run, 254 bits
        start_run(2'b00, 31'h7F, 32'd0, 4'd0);
        @(negedge CLK);
        for (int i = 0; i < 254; i++) begin
            @(negedge CLK);
            ring[i] = PAT_OUT;
        end
        chk("p7_cnt254", 64'(BIT_CNT), 64'd254);
        pv = '0;
        for (int i = 0; i < 14; i++) pv[i] = ring[i];
        chk("p7_head14", pv, 64'h3040);
        mism = 0; ones = 0;
        for (int i = 0; i < 127; i++) begin
            if (ring[i] !== ring[i+127]) mism++;
            ones += int'(ring[i]);
        end
        chk("p7_period127", 64'(mism), 64'd0);
        chk("p7_ones", 64'(ones), 64'd64);
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        wait_done("p7_free_stop_done");

        // PRBS15: masked-zero seed behaves as all-ones
        start_run(2'b01, 31'h7FFF_8000, 32'd40, 4'd0);
        @(negedge CLK);
        av = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            av[i] = PAT_OUT;
        end
        wait_done("p15_zero_done");
        start_run(2'b01, 31'h0000_7FFF, 32'd40, 4'd0);
        @(negedge CLK);
        pv = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            pv[i] = PAT_OUT;
        end
        wait_done("p15_ones_done");
        chk("p15_seed0_bits", av, 64'h3000_4000);
        chk("p15_ones_bits", pv, 64'h3000_4000);

        // PRBS31 free-run, MODE change mid-run, STOP+START at bit 100
        start_run(2'b10, 31'h7FFF_FFFF, 32'd0, 4'd0);
        @(negedge CLK);
        pv = '0;
        for (int i = 0; i < 99; i++) begin
            @(negedge CLK);
            if (i < 32) pv[i] = PAT_OUT;
            if (i == 4) MODE = 2'b11;
        end
        chk("p31_head32", pv, 64'h7000_0000);
        chk("p31_cnt99", 64'(BIT_CNT), 64'd99);
        STOP = 1'b1; START = 1'b1;
        @(negedge CLK);
        STOP = 1'b0; START = 1'b0;
        chk("stop_last_bit_running", 64'(RUNNING), 64'd1);
        chk("stop_cnt100", 64'(BIT_CNT), 64'd100);
        chk("stop_done_not_yet", 64'(DONE), 64'd0);
        @(negedge CLK);
        chk("stop_done", 64'(DONE), 64'd1);
        chk("stop_running_off", 64'(RUNNING), 64'd0);
        chk("stop_pat_zero", 64'(PAT_OUT), 64'd0);
        repeat (3) @(negedge CLK);
        chk("stop_wins_done", 64'(DONE), 64'd1);
        chk("stop_cnt_hold", 64'(BIT_CNT), 64'd100);

        // checkerboard, DLY 5 and DLY 15
        start_run(2'b11, 31'h1234, 32'd30, 4'd5);
        @(negedge CLK);
        pv = '0; rv = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            pv[i] = PAT_OUT;
            rv[i] = RPG_OUT;
        end
        chk("chk_pat", pv, 64'h1555_5555);
        chk("chk_dly5", rv, 64'h2_AAAA_AAA0);
        wait_done("chk_dly5_done");
        start_run(2'b11, 31'h0, 32'd30, 4'd15);
        @(negedge CLK);
        pv = '0; rv = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            pv[i] = PAT_OUT;
            rv[i] = RPG_OUT;
        end
        chk("chk15_pat", pv, 64'h1555_5555);
        chk("chk_dly15", rv, 64'h0AAA_AAAA_8000);
        wait_done("chk_dly15_done");

        // reset asserted mid-run
        start_run(2'b00, 31'h55, 32'd0, 4'd3);
        @(negedge CLK);
        repeat (20) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("mrst_pat", 64'(PAT_OUT), 64'd0);
        chk("mrst_rpg", 64'(RPG_OUT), 64'd0);
        chk("mrst_running", 64'(RUNNING), 64'd0);
        chk("mrst_done", 64'(DONE), 64'd0);
        chk("mrst_cnt", 64'(BIT_CNT), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        chk("mrst_idle_done", 64'(DONE), 64'd0);
        chk("mrst_idle_running", 64'(RUNNING), 64'd0);

`ifdef RPG_ERR_INJECT_EN
        // one pulse in IDLE (dropped), three in RUN
        INJ_ERR = 1'b1;
        @(negedge CLK);
        INJ_ERR = 1'b0;
        start_run(2'b00, 31'h7F, 32'd30, 4'd0);
        @(negedge CLK);
        diff = 0;
        for (int i = 0; i < 40; i++) begin
            INJ_ERR = (i == 3 || i == 10 || i == 20) ? 1'b1 : 1'b0;
            @(negedge CLK);
            if (PAT_OUT !== RPG_OUT) diff++;
        end
        INJ_ERR = 1'b0;
        chk("inj_diff3", 64'(diff), 64'd3);
        chk("inj_cnt", 64'(BIT_CNT), 64'd30);
        wait_done("inj_done");
`else
        diff = 0;
`endif

        // short run from IDLE after reset
        start_run(2'b11, 31'h0, 32'd3, 4'd0);
        wait_done("post_rst_done");
        chk("post_rst_cnt", 64'(BIT_CNT), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
